// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter; the master drives the
// counting controls and the slave (the counter) returns count, carry and flags.
interface updown_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             zero;

  modport master (
    output en, up, load, load_val,
    input  q, tc, wrap, zero
  );

  modport slave (
    input  en, up, load, load_val,
    output q, tc, wrap, zero
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Synchronous modulo-MODULUS up/down counter with clamped parallel load and cascade carry.
// Define COUNTER_SATURATE_EN to saturate at the range ends instead of wrapping.
module updown_mod_counter #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic                clk,
  input  logic                reset,
  updown_mod_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic             wrap_r;
  logic             wrap_next;
  logic             zero_r;
  logic             at_max;
  logic             at_min;

  assign at_max = (cnt == MAX_VAL);
  assign at_min = (cnt == '0);

  always_comb begin
    cnt_next  = cnt;
    wrap_next = 1'b0;
    if (bus.load) begin
      cnt_next = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        if (at_max) begin
`ifdef COUNTER_SATURATE_EN
          cnt_next = MAX_VAL;
`else
          cnt_next  = '0;
          wrap_next = 1'b1;
`endif
        end else begin
          cnt_next = cnt + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
`ifdef COUNTER_SATURATE_EN
          cnt_next = '0;
`else
          cnt_next  = MAX_VAL;
          wrap_next = 1'b1;
`endif
        end else begin
          cnt_next = cnt - WIDTH'(1);
        end
      end
    end
  end

  // zero is registered from cnt_next so it lines up with the q it describes
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      wrap_r <= 1'b0;
      zero_r <= 1'b1;
    end else begin
      cnt    <= cnt_next;
      wrap_r <= wrap_next;
      zero_r <= (cnt_next == '0);
    end
  end

  assign bus.q    = cnt;
  assign bus.wrap = wrap_r;
  assign bus.zero = zero_r;
  assign bus.tc   = bus.en & ((bus.up & at_max) | (~bus.up & at_min));

endmodule

// File: tb/tb_updown_mod_counter.sv
// Two-stage cascaded counter bench: directed scenarios plus random stimulus against an arithmetic model.
module tb_updown_mod_counter;
  localparam int W = 4;
  localparam int M = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  updown_mod_counter_if #(.WIDTH(W)) if0 ();
  updown_mod_counter_if #(.WIDTH(W)) if1 ();

  // stage1 advances only on stage0's carry/borrow
  assign if1.en       = if0.tc;
  assign if1.up       = if0.up;
  assign if1.load     = 1'b0;
  assign if1.load_val = '0;

  updown_mod_counter #(.WIDTH(W), .MODULUS(M)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  updown_mod_counter #(.WIDTH(W), .MODULUS(M)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));

  int tests = 0;
  int fails = 0;
  int mq0 = 0;
  int mq1 = 0;
  bit mw0 = 1'b0;
  bit mw1 = 1'b0;
  bit mvalid = 1'b0;

  function automatic int m_next(int q, bit e, bit u, bit l, int lv);
    if (l) return (lv > M - 1) ? M - 1 : lv;
    if (!e) return q;
`ifdef COUNTER_SATURATE_EN
    if (u) return (q + 1 > M - 1) ? M - 1 : q + 1;
    return (q - 1 < 0) ? 0 : q - 1;
`else
    if (u) return (q + 1) % M;
    return (q + M - 1) % M;
`endif
  endfunction

  // a wrap is a step whose result moved against the counting direction
  function automatic bit m_wrap(int q, int n, bit e, bit u, bit l);
    return e && !l && (u ? (n < q) : (n > q));
  endfunction

  function automatic bit m_tc(int q, bit e, bit u);
    return e && (u ? (q == M - 1) : (q == 0));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit u, input bit l, input int lv);
    bit t0;
    bit t1;
    int n0;
    int n1;
    reset        = r;
    if0.en       = e;
    if0.up       = u;
    if0.load     = l;
    if0.load_val = W'(lv);
    #1;
    t0 = m_tc(mq0, e, u);
    t1 = m_tc(mq1, t0, u);
    if (mvalid) begin
      check("tc0", {31'b0, if0.tc}, {31'b0, t0});
      check("tc1", {31'b0, if1.tc}, {31'b0, t1});
    end
    @(posedge clk);
    #1;
    if (r) begin
      mq0 = 0; mq1 = 0; mw0 = 1'b0; mw1 = 1'b0; mvalid = 1'b1;
    end else begin
      n0  = m_next(mq0, e, u, l, lv);
      n1  = m_next(mq1, t0, u, 1'b0, 0);
      mw0 = m_wrap(mq0, n0, e, u, l);
      mw1 = m_wrap(mq1, n1, t0, u, 1'b0);
      mq0 = n0;
      mq1 = n1;
    end
    check("q0", {28'b0, if0.q}, mq0);
    check("wrap0", {31'b0, if0.wrap}, {31'b0, mw0});
    check("zero0", {31'b0, if0.zero}, (mq0 == 0) ? 32'd1 : 32'd0);
    check("q1", {28'b0, if1.q}, mq1);
    check("wrap1", {31'b0, if1.wrap}, {31'b0, mw1});
    check("zero1", {31'b0, if1.zero}, (mq1 == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    if0.en = 1'b0; if0.up = 1'b1; if0.load = 1'b0; if0.load_val = '0;
    @(posedge clk);
    #1;

    // reset state
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);
    check("rst_q", {28'b0, if0.q}, 32'd0);
    check("rst_zero", {31'b0, if0.zero}, 32'd1);

    // count up through the modulus boundary
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
`ifndef COUNTER_SATURATE_EN
      check("t1_seq", {28'b0, if0.q}, (i + 1) % M);
`endif
    end

    // load, clamped load, load beats enable
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 7);
    check("t2_load7", {28'b0, if0.q}, 32'd7);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 13);
    check("t2_clamp", {28'b0, if0.q}, 32'd9);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 4);
    check("t2_ld_en", {28'b0, if0.q}, 32'd4);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 15);
    check("t2_clamp15", {28'b0, if0.q}, 32'd9);

    // count down through zero
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
`ifndef COUNTER_SATURATE_EN
    check("t3_down", {28'b0, if0.q}, 32'd8);
`endif

    // reset overrides load and enable mid-count
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 5);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 3);
    check("t4_rst_q", {28'b0, if0.q}, 32'd0);
    check("t4_rst_wrap", {31'b0, if0.wrap}, 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
    check("t4_resume", {28'b0, if0.q}, 32'd1);

    // randomized mix of controls
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
    end

    // two-digit decimal cascade
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
`ifndef COUNTER_SATURATE_EN
      check("t5_casc", 32'(if1.q) * 10 + 32'(if0.q), (i + 1) % 100);
`endif
    end

`ifdef COUNTER_SATURATE_EN
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 8);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
      check("t6_sat_up", {28'b0, if0.q}, 32'd9);
      check("t6_nowrap", {31'b0, if0.wrap}, 32'd0);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
      check("t6_sat_dn", {28'b0, if0.q}, 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
